// File: rtl/md5_block_unpacker.sv
// Unpacks one padded 512-bit MD5 block: validates padding/length, then streams the message bytes.
// Optional STRICT_PAD_CHECK_EN: also require the zero-fill bytes between marker and length to be 0.
module md5_block_unpacker #(
    parameter int unsigned MAX_LEN     = 55,
    parameter bit          DROP_ON_ERR = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] in_block,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_byte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [5:0]   msg_len,
    output logic         done,
    output logic         err
);
    localparam logic [5:0] MaxLen = 6'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StCheck, StStream, StDone} state_e;

    state_e       state_q;
    logic [511:0] blk_q;
    logic [5:0]   idx_q;
    logic [5:0]   len_q;
    logic [7:0]   byte_q;
    logic         valid_q;
    logic         last_q;
    logic         ready_q;
    logic         done_q;
    logic         err_q;
    logic         err_flag_q;

    logic [7:0]  blk_bytes [64];
    logic [63:0] bitlen;
    logic [5:0]  cand_len;
    logic [5:0]  clip_len;
    logic [5:0]  nxt_idx;
    logic        bad_len;
    logic        bad_marker;
    logic        bad_fill;
    logic        malformed;

    always_comb begin
        for (int k = 0; k < 64; k++) begin
            blk_bytes[k] = blk_q[511 - 8*k -: 8];
        end
        // Length field is little-endian: byte 56 carries the LSB.
        for (int k = 0; k < 8; k++) begin
            bitlen[8*k +: 8] = blk_bytes[56 + k];
        end
        cand_len   = bitlen[8:3];
        bad_len    = (bitlen[2:0] != 3'd0) || (bitlen[63:9] != 55'd0) || (cand_len > MaxLen);
        bad_marker = (blk_bytes[cand_len] != 8'h80);
        bad_fill   = 1'b0;
`ifdef STRICT_PAD_CHECK_EN
        for (int k = 0; k < 56; k++) begin
            if ((6'(k) > cand_len) && (blk_bytes[k] != 8'h00)) begin
                bad_fill = 1'b1;
            end
        end
`endif
        malformed = bad_len || bad_marker || bad_fill;
        clip_len  = (cand_len > MaxLen) ? MaxLen : cand_len;
        nxt_idx   = idx_q + 6'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            blk_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        blk_q   <= in_block;
                        ready_q <= 1'b0;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    err_flag_q <= malformed;
                    idx_q      <= '0;
                    if ((malformed && DROP_ON_ERR) || (clip_len == 6'd0)) begin
                        len_q   <= (malformed && DROP_ON_ERR) ? 6'd0 : clip_len;
                        done_q  <= 1'b1;
                        err_q   <= malformed;
                        state_q <= StDone;
                    end else begin
                        len_q   <= clip_len;
                        valid_q <= 1'b1;
                        byte_q  <= blk_bytes[0];
                        last_q  <= (clip_len == 6'd1);
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (out_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            byte_q  <= '0;
                            done_q  <= 1'b1;
                            err_q   <= err_flag_q;
                            state_q <= StDone;
                        end else begin
                            idx_q  <= nxt_idx;
                            byte_q <= blk_bytes[nxt_idx];
                            last_q <= (nxt_idx == len_q - 6'd1);
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign out_byte  = byte_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign msg_len   = len_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_md5_block_unpacker.sv
// Directed bench for md5_block_unpacker: vector table plus throttle and mid-stream reset sequences.
module tb_md5_block_unpacker;
    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] in_block;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [5:0]   msg_len;
    logic         done;
    logic         err;

    int n_cmp  = 0;
    int n_fail = 0;

    md5_block_unpacker dut (
        .clk       (clk),
        .rst       (rst),
        .in_block  (in_block),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .msg_len   (msg_len),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] blk;
        int           len;
        bit           err;
        int           nbytes;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] put(input logic [511:0] b, input int k, input logic [7:0] v);
        b[511 - 8*k -: 8] = v;
        return b;
    endfunction

    function automatic logic [7:0] byte_of(input logic [511:0] b, input int k);
        return b[511 - 8*k -: 8];
    endfunction

    function automatic logic [511:0] with_len(input logic [511:0] b, input logic [63:0] bitlen);
        for (int k = 0; k < 8; k++) b = put(b, 56 + k, bitlen[8*k +: 8]);
        return b;
    endfunction

    function automatic logic [511:0] from_str(input string s);
        logic [511:0] b = '0;
        for (int i = 0; i < s.len(); i++) b = put(b, i, s[i]);
        b = put(b, s.len(), 8'h80);
        return with_len(b, 64'(s.len() * 8));
    endfunction

    // Unthrottled block: exact cycle-by-cycle expectations from handshake to return to idle.
    task automatic apply(input vec_t v, input int id);
        @(negedge clk);
        check($sformatf("v%0d_in_ready_idle", id), 64'(in_ready), 64'd1);
        in_block = v.blk;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("v%0d_check_no_valid", id), 64'(out_valid), 64'd0);
        check($sformatf("v%0d_busy", id), 64'(in_ready), 64'd0);
        for (int j = 0; j < v.nbytes; j++) begin
            @(negedge clk);
            check($sformatf("v%0d_out_valid[%0d]", id, j), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_out_byte[%0d]", id, j), 64'(out_byte), 64'(byte_of(v.blk, j)));
            check($sformatf("v%0d_out_last[%0d]", id, j), 64'(out_last), 64'(j == v.nbytes - 1));
        end
        @(negedge clk);
        check($sformatf("v%0d_done", id), 64'(done), 64'd1);
        check($sformatf("v%0d_err", id), 64'(err), 64'(v.err));
        check($sformatf("v%0d_msg_len", id), 64'(msg_len), 64'(v.len));
        check($sformatf("v%0d_valid_off", id), 64'(out_valid), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", id), 64'(done), 64'd0);
        check($sformatf("v%0d_ready_back", id), 64'(in_ready), 64'd1);
        check($sformatf("v%0d_len_held", id), 64'(msg_len), 64'(v.len));
    endtask

    vec_t         vecs [10];
    logic [511:0] b;
    logic [511:0] blk_t;
    bit           pat [4];
    int           acc;
    int           last_acc_cyc;
    bit           stalled;
    bit           seen_done;
    logic [7:0]   held;

    initial begin
        rst       = 1'b1;
        in_block  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        b = '0;
        for (int k = 0; k < 55; k++) b = put(b, k, 8'(k + 1));
        b = put(b, 55, 8'h80);

        vecs[0] = '{from_str("test"), 4, 1'b0, 4};
        vecs[1] = '{from_str(""), 0, 1'b0, 0};
        vecs[2] = '{with_len(b, 64'h1B8), 55, 1'b0, 55};
        vecs[3] = '{put(from_str("test"), 4, 8'h81), 0, 1'b1, 0};
        vecs[4] = '{with_len(from_str("test"), 64'h21), 0, 1'b1, 0};
        vecs[5] = '{with_len(b, 64'h1C0), 0, 1'b1, 0};
        vecs[6] = '{with_len(from_str("test"), 64'h1_0000_0020), 0, 1'b1, 0};
`ifdef STRICT_PAD_CHECK_EN
        vecs[7] = '{put(from_str("test"), 40, 8'h5A), 0, 1'b1, 0};
`else
        vecs[7] = '{put(from_str("test"), 40, 8'h5A), 4, 1'b0, 4};
`endif
        vecs[8] = '{from_str("abc"), 3, 1'b0, 3};
        vecs[9] = '{from_str("a"), 1, 1'b0, 1};

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_byte", 64'(out_byte), 64'd0);
        check("rst_msg_len", 64'(msg_len), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) apply(vecs[i], i);

        // Throttled "test": out_ready pattern 1,0,0,1 repeating.
        pat          = '{1'b1, 1'b0, 1'b0, 1'b1};
        blk_t        = from_str("test");
        acc          = 0;
        last_acc_cyc = -10;
        stalled      = 1'b0;
        seen_done    = 1'b0;
        held         = '0;
        @(negedge clk);
        in_block = blk_t;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            @(negedge clk);
            if (done) begin
                seen_done = 1'b1;
                check("thr_done_timing", 64'(c), 64'(last_acc_cyc + 1));
                check("thr_count", 64'(acc), 64'd4);
                check("thr_err", 64'(err), 64'd0);
            end else if (out_valid) begin
                check($sformatf("thr_byte[%0d]", acc), 64'(out_byte), 64'(byte_of(blk_t, acc)));
                check($sformatf("thr_last[%0d]", acc), 64'(out_last), 64'(acc == 3));
                if (stalled) check("thr_hold", 64'(out_byte), 64'(held));
                out_ready = pat[c % 4];
                stalled   = !out_ready;
                held      = out_byte;
                if (out_ready) begin
                    acc++;
                    last_acc_cyc = c;
                end
            end
        end
        check("thr_done_seen", 64'(seen_done), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);

        // Reset after the second streamed byte of "test".
        in_block = blk_t;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_byte0", 64'(out_byte), 64'h74);
        @(negedge clk);
        check("mid_byte1", 64'(out_byte), 64'h65);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_last", 64'(out_last), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_len", 64'(msg_len), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_ready_after", 64'(in_ready), 64'd1);
        check("mid_no_done", 64'(done), 64'd0);
        apply(vecs[8], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/md5_block_unpacker.md
Name: md5_block_unpacker

Overview:
Decoder for the MD5 padding stage. Accepts one padded 512-bit MD5 block, as produced on md5core message_out. Validates the padding and length field, recovers the candidate message length, then streams the original message bytes out one per cycle over a valid/ready handshake. Sits between the hasher and the result-readout path, so a matched candidate can be reported byte-wise.

Parameters:
MAX_LEN, 55, largest accepted message length in bytes; legal values 1..55.
DROP_ON_ERR, 1, 1 = discard a malformed block without streaming; 0 = stream the declared length anyway and still flag err.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_block  input  512  padded MD5 block
in_valid  input  1  in_block valid
in_ready  output  1  block accepted when in_valid && in_ready
out_byte  output  8  message byte
out_valid  output  1  out_byte valid
out_ready  input  1  downstream accepts byte
out_last  output  1  marks final message byte
msg_len  output  6  decoded length in bytes, held until next accepted block
done  output  1  one-cycle pulse: block finished (streamed or dropped)
err  output  1  one-cycle pulse, coincident with done, on malformed block

Behaviour:
- Byte k of a block = in_block[511-8k -: 8], k = 0..63. Message occupies bytes 0..L-1. Byte L = 0x80. Bytes L+1..55 = 0x00. Bytes 56..63 hold the bit length, little-endian (byte 56 = LSB).
- Reset (async, any state): state IDLE, in_ready=1, out_valid=0, out_last=0, out_byte=0, msg_len=0, done=0, err=0, internal block register cleared.
- IDLE: in_ready=1. On handshake, latch in_block and go to CHECK. in_ready is 0 in every other state.
- CHECK (1 cycle): bitlen = 64-bit field. Malformed if any of:
  - bitlen[2:0] != 0
  - bitlen/8 > MAX_LEN
  - bytes 56..63 upper bits nonzero beyond the 9 needed
  - byte L != 0x80
  - zero-fill check fails (see Optional Feature)
- CHECK transitions:
  - Valid, L=0: go to DONE.
  - Valid, L>0: msg_len=L, go to STREAM.
  - Malformed, DROP_ON_ERR=1: msg_len=0, go to DONE with err.
  - Malformed, DROP_ON_ERR=0: msg_len=min(L,MAX_LEN), go to STREAM (or DONE if that is 0), err flag latched.
- STREAM: byte index idx starts at 0. out_valid=1, out_byte=byte idx, out_last=(idx==msg_len-1). On out_valid&&out_ready, idx increments. When the last byte is accepted, go to DONE. out_byte/out_last are stable while out_valid && !out_ready.
- DONE (1 cycle): done=1, err=latched flag, then IDLE.
- Latency: block handshake in cycle N -> first out_valid in N+2. Unthrottled throughput is 1 byte/cycle. Block-to-block minimum period is L+3 cycles.
- Reset mid-STREAM: outputs drop immediately; the partial message is abandoned; no done pulse.
- in_valid asserted outside IDLE is ignored (not accepted); the upstream holds it.

Optional Feature:
Macro STRICT_PAD_CHECK_EN.
- Defined: bytes L+1..55 must all be 0x00, otherwise the block is malformed.
- Undefined: zero-fill bytes are not inspected; only the 0x80 marker and the length field are checked.

Test Plan:
- "test" block (bytes 74 65 73 74 80 00.., byte56=0x20) with out_ready=1 -> bytes 74,65,73,74 on cycles N+2..N+5; out_last on 0x74 at N+5; msg_len=4; done at N+6; err=0.
- Same block, out_ready toggled 1,0,0,1,... -> identical byte order; out_byte held during stalls; done follows the 4th accepted byte.
- Empty message (byte0=0x80, length 0) -> no out_valid; done at N+2; msg_len=0; err=0.
- 55-byte message, byte55=0x80, length 0x1B8 -> 55 bytes streamed; out_last only on the 55th; msg_len=55.
- Byte L=0x81 with DROP_ON_ERR=1 -> no bytes; done+err at N+2. Nonzero fill byte 40 with L=4 -> err only when STRICT_PAD_CHECK_EN is defined.
- rst asserted after the 2nd byte of "test" -> out_valid=0 immediately; in_ready=1 after release; next block decodes normally.
